// File: rtl/store_chk_pkg.sv
// Shared types and helpers for the store-stream checker.
package store_chk_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PASS    = 2'd1,
        FAIL    = 2'd2,
        TIMEOUT = 2'd3
    } chk_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } store_entry_t;

    // Narrower counters pass their own ceiling as limit, zero-extended.
    function automatic logic [15:0] sat_inc(input logic [15:0] value, input logic [15:0] limit);
        return (value >= limit) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/store_log_fifo.sv
// Fall-through synchronous FIFO of store entries; head reads as zero when empty.
module store_log_fifo
    import store_chk_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  store_entry_t din,
    output logic         full,
    output logic         empty,
    output store_entry_t head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    store_entry_t mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    // A pop frees the slot being written when full, so both may proceed.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mem_store_checker.sv
// Watches committed stores, decides pass/fail/timeout and logs every accepted store.
module mem_store_checker
    import store_chk_pkg::*;
#(
    parameter logic [31:0] PASS_ADDR      = 32'd100,
    parameter logic [31:0] PASS_DATA      = 32'd25,
    parameter logic [31:0] SCRATCH_ADDR   = 32'd96,
    parameter int          DEPTH          = 8,
    parameter int          TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    input  logic        log_ready,
    output logic        log_valid,
    output logic [31:0] log_addr,
    output logic [31:0] log_data,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [15:0] store_count,
    output logic [7:0]  dropped
);

    chk_state_t   state;
    chk_state_t   state_next;
    logic [31:0]  idle_cnt;
    logic [31:0]  idle_next;
    logic [31:0]  idle_inc;
    logic         store_acc;
    logic         fifo_full;
    logic         fifo_empty;
    logic         drop;
    logic [15:0]  count_inc;
    logic [15:0]  drop_inc;
    store_entry_t entry_in;
    store_entry_t head;

    assign idle_inc  = idle_cnt + 32'd1;
    assign store_acc = MemWrite && (state == RUN);
    assign drop      = store_acc && fifo_full && !log_ready;
    assign count_inc = sat_inc(store_count, 16'hFFFF);
    assign drop_inc  = sat_inc({8'h00, dropped}, 16'h00FF);
    assign entry_in  = '{addr: DataAdr, data: WriteData};

    // A store seen on the threshold cycle takes priority over the timeout.
    always_comb begin
        state_next = state;
        idle_next  = idle_cnt;
        case (state)
            RUN: begin
                if (MemWrite) begin
                    idle_next = '0;
                    if (DataAdr == PASS_ADDR && WriteData == PASS_DATA)
                        state_next = PASS;
                    else if (DataAdr == SCRATCH_ADDR)
                        state_next = RUN;
                    else
                        state_next = FAIL;
                end else if (idle_inc == 32'(TIMEOUT_CYCLES)) begin
                    state_next = TIMEOUT;
                end else begin
                    idle_next = idle_inc;
                end
            end
            default: state_next = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            idle_cnt    <= '0;
            store_count <= '0;
            dropped     <= '0;
        end else begin
            state    <= state_next;
            idle_cnt <= idle_next;
            if (store_acc) store_count <= count_inc;
            if (drop)      dropped     <= drop_inc[7:0];
        end
    end

    store_log_fifo #(
        .DEPTH(DEPTH)
    ) u_log (
        .clk   (clk),
        .reset (reset),
        .push  (store_acc),
        .pop   (log_ready),
        .din   (entry_in),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    assign log_valid = !fifo_empty;
    assign log_addr  = head.addr;
    assign log_data  = head.data;
    assign pass      = (state == PASS);
    assign fail      = (state == FAIL);
    assign timeout   = (state == TIMEOUT);
    assign done      = (state != RUN);

endmodule

// File: tb/tb_mem_store_checker.sv
// Directed bench for mem_store_checker: verdict checks plus a queue-based log scoreboard.
module tb_mem_store_checker;
    import store_chk_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;
    logic        log_ready = 1'b0;
    logic        log_valid;
    logic [31:0] log_addr;
    logic [31:0] log_data;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [15:0] store_count;
    logic [7:0]  dropped;

    store_entry_t exp_q[$];
    int compared = 0;
    int mismatched = 0;

    mem_store_checker dut (
        .clk         (clk),
        .reset       (reset),
        .MemWrite    (MemWrite),
        .DataAdr     (DataAdr),
        .WriteData   (WriteData),
        .log_ready   (log_ready),
        .log_valid   (log_valid),
        .log_addr    (log_addr),
        .log_data    (log_data),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .timeout     (timeout),
        .store_count (store_count),
        .dropped     (dropped)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Log monitor: compares the head whenever the DUT will pop it on the next edge.
    always @(negedge clk) begin
        if (!reset && log_valid && log_ready) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL log_unexpected: got addr 0x%0h data 0x%0h, expected nothing", log_addr, log_data);
            end else begin
                checkOutput("log_addr", log_addr, exp_q[0].addr);
                checkOutput("log_data", log_data, exp_q[0].data);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input bit logged);
        MemWrite  = 1'b1;
        DataAdr   = addr;
        WriteData = data;
        if (logged) exp_q.push_back('{addr: addr, data: data});
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
    endtask

    task automatic doReset();
        log_ready = 1'b0;
        MemWrite  = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic checkResetState();
        checkOutput("rst_log_valid", 32'(log_valid), 32'd0);
        checkOutput("rst_log_addr", log_addr, 32'd0);
        checkOutput("rst_log_data", log_data, 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_pass", 32'(pass), 32'd0);
        checkOutput("rst_fail", 32'(fail), 32'd0);
        checkOutput("rst_timeout", 32'(timeout), 32'd0);
        checkOutput("rst_store_count", 32'(store_count), 32'd0);
        checkOutput("rst_dropped", 32'(dropped), 32'd0);
    endtask

    task automatic waitDrain(input string name);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput({name, "_pending"}, 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        checkOutput({name, "_log_valid"}, 32'(log_valid), 32'd0);
    endtask

    initial begin
        doReset();
        checkResetState();

        // Two scratch stores then the pass store.
        log_ready = 1'b1;
        applyStimulus(32'd96, 32'd7, 1'b1);
        applyStimulus(32'd96, 32'd7, 1'b1);
        checkOutput("t1_pass_early", 32'(pass), 32'd0);
        applyStimulus(32'd100, 32'd25, 1'b1);
        checkOutput("t1_pass", 32'(pass), 32'd1);
        checkOutput("t1_done", 32'(done), 32'd1);
        checkOutput("t1_count", 32'(store_count), 32'd3);
        waitDrain("t1");

        // Illegal address fails; later stores are ignored.
        doReset();
        log_ready = 1'b1;
        applyStimulus(32'd96, 32'd5, 1'b1);
        applyStimulus(32'd104, 32'd25, 1'b1);
        checkOutput("t2_fail", 32'(fail), 32'd1);
        checkOutput("t2_done", 32'(done), 32'd1);
        applyStimulus(32'd100, 32'd25, 1'b0);
        checkOutput("t2_fail_hold", 32'(fail), 32'd1);
        checkOutput("t2_pass", 32'(pass), 32'd0);
        checkOutput("t2_count", 32'(store_count), 32'd2);
        waitDrain("t2");

        // Wrong data at the pass address.
        doReset();
        log_ready = 1'b1;
        applyStimulus(32'd100, 32'd24, 1'b1);
        checkOutput("t3_fail", 32'(fail), 32'd1);
        checkOutput("t3_pass", 32'(pass), 32'd0);
        checkOutput("t3_count", 32'(store_count), 32'd1);
        waitDrain("t3");

        // Idle timeout fires on the 1000th store-free edge.
        doReset();
        repeat (999) @(posedge clk);
        #1;
        checkOutput("t4_timeout_early", 32'(timeout), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("t4_timeout", 32'(timeout), 32'd1);
        checkOutput("t4_done", 32'(done), 32'd1);
        checkOutput("t4_count", 32'(store_count), 32'd0);

        // Store on the threshold edge wins.
        doReset();
        log_ready = 1'b1;
        repeat (999) @(posedge clk);
        #1;
        applyStimulus(32'd100, 32'd25, 1'b1);
        checkOutput("t4b_pass", 32'(pass), 32'd1);
        checkOutput("t4b_timeout", 32'(timeout), 32'd0);
        waitDrain("t4b");

        // Overflow: ten stores into an eight-entry log with no consumer.
        doReset();
        for (int i = 0; i < 10; i++)
            applyStimulus(32'd96, 32'h10 + 32'(i), i < 8);
        checkOutput("t5_dropped", 32'(dropped), 32'd2);
        checkOutput("t5_count", 32'(store_count), 32'd10);
        checkOutput("t5_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("t5_hold_addr", log_addr, 32'd96);
        checkOutput("t5_hold_data", log_data, 32'h10);
        log_ready = 1'b1;
        waitDrain("t5");

        // Reset while in PASS with three logged entries.
        doReset();
        applyStimulus(32'd96, 32'd1, 1'b1);
        applyStimulus(32'd96, 32'd2, 1'b1);
        applyStimulus(32'd100, 32'd25, 1'b1);
        checkOutput("t6_pass", 32'(pass), 32'd1);
        checkOutput("t6_log_valid", 32'(log_valid), 32'd1);
        doReset();
        checkResetState();
        log_ready = 1'b1;
        applyStimulus(32'd100, 32'd25, 1'b1);
        checkOutput("t6_repass", 32'(pass), 32'd1);
        checkOutput("t6_recount", 32'(store_count), 32'd1);
        waitDrain("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
